// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes, multi-cycle data-memory freezes with a sticky timeout halt, and perf counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memRead,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam logic [REG_W-1:0] XZR     = REG_W'(31);
    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             mem_miss;
    logic             br_flush;

    assign load_use = ex_memRead && (ex_rd != XZR) &&
                      ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    assign mem_miss = mem_req && !mem_ack;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        br_flush     = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;

        unique case (state_q)
            RUN: begin
                if (mem_miss) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    wait_cnt_d   = 8'd1;
                    state_d      = (TIMEOUT <= 8'd1) ? HALT : MEM_WAIT;
                end else if (ex_br_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    br_flush    = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                // The ack cycle itself releases the pipeline; held EX/ID events are seen next cycle.
                if (mem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_bubble = 1'b1;
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                    if (wait_cnt_d >= TIMEOUT) state_d = HALT;
                end
            end
            HALT: begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_en     = 1'b0;
                memwb_bubble = 1'b1;
            end
            default: state_d = RUN;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        flush_cnt_d = flush_cnt_q;
        if (br_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);

        // Reset overrides every control so nothing advances while it is held.
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so all registers update from pre-edge values.
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = (state_q == HALT);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with 4-bit counters
// shares the stimulus to observe counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] CTL_RUN = 7'b1101010;
    localparam logic [6:0] CTL_LU  = 7'b0001110;
    localparam logic [6:0] CTL_BR  = 7'b1111110;
    localparam logic [6:0] CTL_FRZ = 7'b0000001;
    localparam logic [6:0] CTL_RST = 7'b0010101;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic       id_uses_rm, ex_memRead, ex_br_taken, mem_req, mem_ack;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_bubble, s_exmem_en, s_memwb_bubble, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4), .MEM_TIMEOUT(15)) dut_sat (
        .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
        .ifid_flush(s_ifid_flush), .idex_en(s_idex_en), .idex_bubble(s_idex_bubble),
        .exmem_en(s_exmem_en), .memwb_bubble(s_memwb_bubble), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}),
              32'(exp));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0; id_uses_rm = 1'b0;
        ex_memRead = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        cycle();
        check_ctl("reset_ctl", CTL_RST);
        cycle();
        check("reset_stall", 32'(stall_cnt), 32'd0);
        check("reset_flush", 32'(flush_cnt), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        #1;
        check_ctl("idle_ctl", CTL_RUN);
        cycle();
        check("idle_stall", 32'(stall_cnt), 32'd0);

        // Load-use on rn
        ex_memRead = 1'b1; ex_rd = 5'd3; id_rn = 5'd3;
        #1 check_ctl("lu_rn_ctl", CTL_LU);
        cycle();
        check("lu_rn_stall", 32'(stall_cnt), 32'd1);

        // XZR never hazards
        ex_rd = 5'd31; id_rn = 5'd31;
        #1 check_ctl("xzr_ctl", CTL_RUN);
        cycle();
        check("xzr_stall", 32'(stall_cnt), 32'd1);

        // rm match gated by id_uses_rm
        ex_rd = 5'd5; id_rn = 5'd0; id_rm = 5'd5; id_uses_rm = 1'b0;
        #1 check_ctl("rm_unused_ctl", CTL_RUN);
        cycle();
        id_uses_rm = 1'b1;
        #1 check_ctl("rm_used_ctl", CTL_LU);
        cycle();
        check("rm_used_stall", 32'(stall_cnt), 32'd2);

        // Taken branch
        clear_in();
        ex_br_taken = 1'b1;
        #1 check_ctl("br_ctl", CTL_BR);
        cycle();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);

        // Branch beats load-use
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rm = 5'd5; id_uses_rm = 1'b1;
        #1 check_ctl("br_over_lu_ctl", CTL_BR);
        cycle();
        check("br_over_lu_flush", 32'(flush_cnt), 32'd2);
        check("br_over_lu_stall", 32'(stall_cnt), 32'd2);

        // Memory miss: three frozen cycles with a held branch, then ack
        clear_in();
        ex_br_taken = 1'b1; mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_ctl($sformatf("miss_frz%0d_ctl", i), CTL_FRZ);
            cycle();
        end
        check("miss_stall", 32'(stall_cnt), 32'd5);
        check("miss_flush_held", 32'(flush_cnt), 32'd2);
        mem_ack = 1'b1;
        #1 check_ctl("ack_resume_ctl", CTL_RUN);
        cycle();
        check("ack_stall", 32'(stall_cnt), 32'd5);
        mem_req = 1'b0; mem_ack = 1'b0;
        #1 check_ctl("post_ack_br_ctl", CTL_BR);
        cycle();
        check("post_ack_flush", 32'(flush_cnt), 32'd3);

        // Zero-wait access lets load-use through
        clear_in();
        mem_req = 1'b1; mem_ack = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd3; id_rn = 5'd3;
        #1 check_ctl("zero_wait_lu_ctl", CTL_LU);
        cycle();
        check("zero_wait_stall", 32'(stall_cnt), 32'd6);

        // Timeout: 15 un-acked wait cycles then sticky halt
        clear_in();
        mem_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1 check($sformatf("to_wait%0d_halted", i), 32'(halted), 32'd0);
            cycle();
        end
        check("to_halted", 32'(halted), 32'd1);
        check_ctl("to_halt_ctl", CTL_FRZ);
        check("to_stall", 32'(stall_cnt), 32'd21);
        mem_ack = 1'b1; ex_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("halt_sticky", 32'(halted), 32'd1);
        check_ctl("halt_sticky_ctl", CTL_FRZ);
        check("halt_stall", 32'(stall_cnt), 32'd24);
        check("halt_flush", 32'(flush_cnt), 32'd3);
        clear_in();
        rst = 1'b1;
        #1 check_ctl("rst2_ctl", CTL_RST);
        cycle();
        rst = 1'b0;
        #1;
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_stall", 32'(stall_cnt), 32'd0);
        check("rst2_flush", 32'(flush_cnt), 32'd0);
        check_ctl("rst2_run_ctl", CTL_RUN);

        // Saturation on the 4-bit instance
        ex_memRead = 1'b1; ex_rd = 5'd7; id_rn = 5'd7;
        for (int i = 0; i < 15; i++) cycle();
        check("sat15_narrow", 32'(s_stall_cnt), 32'd15);
        for (int i = 0; i < 5; i++) cycle();
        check("sat20_narrow", 32'(s_stall_cnt), 32'd15);
        check("sat20_wide", 32'(stall_cnt), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
